// File: rtl/math_engine_sched.sv
// Round-robin scheduler sharing one math_engine between NUM_REQ requesters.
// Validates each command, issues it with a one-cycle strobe and returns a per-requester response.
module math_engine_sched #(
  parameter int unsigned  NUM_REQ    = 4,
  parameter int unsigned  SRAM0_AW   = 16,
  parameter logic [7:0]   OP_G_EXP   = 8'h20,
  parameter logic [7:0]   OP_G_LOG   = 8'h21,
  parameter logic [7:0]   OP_G_SQRT  = 8'h22,
  parameter logic [7:0]   OP_G_RSQRT = 8'h23,
  localparam int unsigned IDW        = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [8*NUM_REQ-1:0]  req_opcode,
  input  logic [16*NUM_REQ-1:0] req_src_base,
  input  logic [16*NUM_REQ-1:0] req_dst_base,
  input  logic [16*NUM_REQ-1:0] req_length,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_err,
  output logic                  me_cmd_valid,
  output logic [7:0]            me_cmd_opcode,
  output logic [15:0]           me_cmd_src_base,
  output logic [15:0]           me_cmd_dst_base,
  output logic [15:0]           me_cmd_length,
  input  logic                  me_busy,
  input  logic                  me_done,
  output logic                  sched_busy,
  output logic [IDW-1:0]        grant_id,
  output logic [31:0]           cmd_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [16:0] AddrLimit = 17'd1 << SRAM0_AW;
  localparam logic [NUM_REQ-1:0] OneHot0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, grant_q, win_id;
  logic           win_found, accept, win_err, op_ok;
  logic           err_q, err_d;
  logic [7:0]     op_q;
  logic [15:0]    src_q, dst_q, len_q;
  logic [31:0]    count_q;
  logic [7:0]     win_op;
  logic [15:0]    win_src, win_dst, win_len;
  logic [16:0]    src_end, dst_end;
  int unsigned    idx;

  logic [7:0]  op_arr  [NUM_REQ];
  logic [15:0] src_arr [NUM_REQ];
  logic [15:0] dst_arr [NUM_REQ];
  logic [15:0] len_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]  = req_opcode[8*g +: 8];
    assign src_arr[g] = req_src_base[16*g +: 16];
    assign dst_arr[g] = req_dst_base[16*g +: 16];
    assign len_arr[g] = req_length[16*g +: 16];
  end

  // Search starts just after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req_valid[IDW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  assign win_op  = op_arr[win_id];
  assign win_src = src_arr[win_id];
  assign win_dst = dst_arr[win_id];
  assign win_len = len_arr[win_id];

  assign src_end = {1'b0, win_src} + {1'b0, win_len};
  assign dst_end = {1'b0, win_dst} + {1'b0, win_len};
  assign op_ok   = (win_op == OP_G_EXP) || (win_op == OP_G_LOG) ||
                   (win_op == OP_G_SQRT) || (win_op == OP_G_RSQRT);
  assign win_err = !op_ok || (win_len == 16'd0) ||
                   (src_end > AddrLimit) || (dst_end > AddrLimit);

  assign accept    = (state_q == StIdle) && !me_busy && win_found && !rst;
  assign req_ready = accept ? (OneHot0 << win_id) : '0;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          err_d   = win_err;
          state_d = win_err ? StResp : StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (me_done) begin
          err_d   = 1'b0;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      last_q  <= IDW'(NUM_REQ - 1);
      grant_q <= '0;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        last_q  <= win_id;
        grant_q <= win_id;
        op_q    <= win_op;
        src_q   <= win_src;
        dst_q   <= win_dst;
        len_q   <= win_len;
      end
      if (state_q == StResp && !err_q) count_q <= count_q + 32'd1;
    end
  end

  assign me_cmd_valid    = (state_q == StIssue);
  assign me_cmd_opcode   = op_q;
  assign me_cmd_src_base = src_q;
  assign me_cmd_dst_base = dst_q;
  assign me_cmd_length   = len_q;
  assign rsp_valid       = (state_q == StResp) ? (OneHot0 << grant_q) : '0;
  assign rsp_err         = (state_q == StResp) && err_q;
  assign sched_busy      = (state_q != StIdle);
  assign grant_id        = grant_q;
  assign cmd_count       = count_q;

endmodule

// File: tb/tb_math_engine_sched.sv
// Directed bench for math_engine_sched with a behavioural engine (done 5L+1 cycles after strobe).
module tb_math_engine_sched;

  localparam logic [7:0] OP_EXP   = 8'h20;
  localparam logic [7:0] OP_LOG   = 8'h21;
  localparam logic [7:0] OP_SQRT  = 8'h22;
  localparam logic [7:0] OP_RSQRT = 8'h23;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_opcode;
  logic [63:0] req_src_base, req_dst_base, req_length;
  logic [3:0]  rsp_valid;
  logic        rsp_err;
  logic        me_cmd_valid;
  logic [7:0]  me_cmd_opcode;
  logic [15:0] me_cmd_src_base, me_cmd_dst_base, me_cmd_length;
  logic        me_busy, me_done;
  logic        sched_busy;
  logic [1:0]  grant_id;
  logic [31:0] cmd_count;

  logic eng_busy, eng_done, force_busy, spur_done;
  int   eng_rem;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  assign me_busy = eng_busy | force_busy;
  assign me_done = eng_done | spur_done;

  math_engine_sched #(
    .NUM_REQ   (4),
    .SRAM0_AW  (16),
    .OP_G_EXP  (OP_EXP),
    .OP_G_LOG  (OP_LOG),
    .OP_G_SQRT (OP_SQRT),
    .OP_G_RSQRT(OP_RSQRT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_opcode     (req_opcode),
    .req_src_base   (req_src_base),
    .req_dst_base   (req_dst_base),
    .req_length     (req_length),
    .rsp_valid      (rsp_valid),
    .rsp_err        (rsp_err),
    .me_cmd_valid   (me_cmd_valid),
    .me_cmd_opcode  (me_cmd_opcode),
    .me_cmd_src_base(me_cmd_src_base),
    .me_cmd_dst_base(me_cmd_dst_base),
    .me_cmd_length  (me_cmd_length),
    .me_busy        (me_busy),
    .me_done        (me_done),
    .sched_busy     (sched_busy),
    .grant_id       (grant_id),
    .cmd_count      (cmd_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: busy from the strobe on, done pulse 5L+1 cycles after the strobe cycle.
  initial begin
    eng_busy = 1'b0;
    eng_done = 1'b0;
    eng_rem  = 0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (eng_rem > 0) begin
        eng_rem = eng_rem - 1;
        if (eng_rem == 0) eng_done = 1'b1;
      end else begin
        eng_busy = 1'b0;
      end
      if (me_cmd_valid) begin
        eng_rem  = 5 * int'(me_cmd_length) + 1;
        eng_busy = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] id, input logic [7:0] op, input logic [15:0] src,
                         input logic [15:0] dst, input logic [15:0] len);
    req_opcode[{id, 3'b000} +: 8]    = op;
    req_src_base[{id, 4'b0000} +: 16] = src;
    req_dst_base[{id, 4'b0000} +: 16] = dst;
    req_length[{id, 4'b0000} +: 16]   = len;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_ready(input logic [1:0] id, input int bound, output int acc);
    int n = 0;
    while (!req_ready[id] && n < bound) begin
      tick();
      n++;
    end
    acc = req_ready[id] ? cyc : -1;
  endtask

  task automatic wait_rsp(input int bound, output int at);
    int n = 0;
    while (rsp_valid == 4'b0000 && n < bound) begin
      tick();
      n++;
    end
    at = (rsp_valid != 4'b0000) ? cyc : -1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    req_valid    = '0;
    req_opcode   = '0;
    req_src_base = '0;
    req_dst_base = '0;
    req_length   = '0;
    force_busy   = 1'b0;
    spur_done    = 1'b0;
    tick();
    tick();
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready_in_rst: got %b expected 0000", req_ready);
    end
    req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({sched_busy, me_cmd_valid, rsp_valid, rsp_err, req_ready} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0", {sched_busy, me_cmd_valid, rsp_valid,
               rsp_err, req_ready});
    end
    n_cmp++;
    if ({grant_id, cmd_count} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_counts: grant %0d count %0d expected 0 0", grant_id, cmd_count);
    end
    n_cmp++;
    if ({me_cmd_opcode, me_cmd_src_base, me_cmd_dst_base, me_cmd_length} !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_cmd_fields: got %h expected 0", {me_cmd_opcode, me_cmd_src_base,
               me_cmd_dst_base, me_cmd_length});
    end
  endtask

  task automatic test_single_exp();
    int a, at, pulses, n;
    set_req(2'd0, OP_EXP, 16'h0100, 16'h0200, 16'd3);
    #1;
    wait_ready(2'd0, 20, a);
    n_cmp++;
    if (a < 0 || req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_accept: ready %b expected 0001", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    n_cmp++;
    if ({me_cmd_valid, me_cmd_opcode, me_cmd_src_base, me_cmd_dst_base, me_cmd_length} !==
        {1'b1, OP_EXP, 16'h0100, 16'h0200, 16'd3}) begin
      n_fail++;
      $display("FAIL single_issue: got v=%b op=%h src=%h dst=%h len=%0d expected 1 20 0100 0200 3",
               me_cmd_valid, me_cmd_opcode, me_cmd_src_base, me_cmd_dst_base, me_cmd_length);
    end
    pulses = me_cmd_valid ? 1 : 0;
    n = 0;
    while (rsp_valid == 4'b0000 && n < 40) begin
      tick();
      if (me_cmd_valid) pulses++;
      n++;
    end
    at = (rsp_valid != 4'b0000) ? cyc : -1;
    n_cmp++;
    if (at != a + 18 || rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: at +%0d valid %b err %b expected +18 0001 0", at - a, rsp_valid,
               rsp_err);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL single_strobe_count: got %0d expected 1", pulses);
    end
    tick();
    n_cmp++;
    if (cmd_count !== 32'd1 || sched_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_count: count %0d busy %b expected 1 0", cmd_count, sched_busy);
    end
  endtask

  task automatic test_round_robin();
    int          exp_ord [5] = '{0, 1, 2, 3, 0};
    int          a, at, n;
    int          prev_a = 0;
    logic [3:0]  oh;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(2'(i), OP_LOG, 16'(16 * i), 16'(256 + i), 16'd1);
    #1;
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << exp_ord[g];
      n = 0;
      while (req_ready == 4'b0000 && n < 30) begin
        tick();
        n++;
      end
      a = cyc;
      n_cmp++;
      if (req_ready !== oh || me_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_grant%0d: ready %b busy %b expected %b 0", g, req_ready, me_busy, oh);
      end
      if (g > 0) begin
        n_cmp++;
        if (a != prev_a + 9) begin
          n_fail++;
          $display("FAIL rr_gap%0d: got %0d expected 9", g, a - prev_a);
        end
      end
      prev_a = a;
      tick();
      if (g == 4) req_valid = '0;
      wait_rsp(30, at);
      n_cmp++;
      if (at != a + 8 || rsp_valid !== oh || rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_rsp%0d: at +%0d valid %b err %b expected +8 %b 0", g, at - a, rsp_valid,
                 rsp_err, oh);
      end
      tick();
    end
    n_cmp++;
    if (cmd_count !== 32'd5 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rr_count: count %0d ready %b expected 5 0000", cmd_count, req_ready);
    end
  endtask

  localparam logic [1:0]  T_ID  [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  localparam logic [7:0]  T_OP  [7] = '{8'h20, 8'hFF, 8'h22, 8'h23, 8'h21, 8'h20, 8'h24};
  localparam logic [15:0] T_SRC [7] = '{16'h0000, 16'h0010, 16'hFFFF, 16'hFFFE, 16'h0000,
                                        16'h0000, 16'h0000};
  localparam logic [15:0] T_DST [7] = '{16'h0000, 16'h0020, 16'h0000, 16'h0000, 16'hFFF0,
                                        16'hFFF0, 16'h0000};
  localparam logic [15:0] T_LEN [7] = '{16'd0, 16'd4, 16'd2, 16'd2, 16'h11, 16'h10, 16'd1};
  localparam logic        T_ERR [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic test_rejections();
    int         a, at;
    logic [3:0] oh;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      oh = 4'b0001 << T_ID[k];
      set_req(T_ID[k], T_OP[k], T_SRC[k], T_DST[k], T_LEN[k]);
      #1;
      wait_ready(T_ID[k], 20, a);
      n_cmp++;
      if (a < 0 || req_ready !== oh) begin
        n_fail++;
        $display("FAIL rej_accept%0d: ready %b expected %b", k, req_ready, oh);
      end
      tick();
      req_valid = '0;
      if (T_ERR[k]) begin
        n_cmp++;
        if (rsp_valid !== oh || rsp_err !== 1'b1 || me_cmd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rej_err%0d: valid %b err %b cmd %b expected %b 1 0", k, rsp_valid,
                   rsp_err, me_cmd_valid, oh);
        end
        tick();
        n_cmp++;
        if (sched_busy !== 1'b0 || rsp_valid !== 4'b0000) begin
          n_fail++;
          $display("FAIL rej_idle%0d: busy %b valid %b expected 0 0000", k, sched_busy, rsp_valid);
        end
      end else begin
        n_cmp++;
        if (me_cmd_valid !== 1'b1 || me_cmd_src_base !== T_SRC[k] ||
            me_cmd_dst_base !== T_DST[k] || me_cmd_length !== T_LEN[k]) begin
          n_fail++;
          $display("FAIL rej_boundary_issue%0d: v %b src %h dst %h len %h expected 1 %h %h %h", k,
                   me_cmd_valid, me_cmd_src_base, me_cmd_dst_base, me_cmd_length, T_SRC[k],
                   T_DST[k], T_LEN[k]);
        end
        wait_rsp(120, at);
        n_cmp++;
        if (at != a + 3 + 5 * int'(T_LEN[k]) || rsp_valid !== oh || rsp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rej_boundary_rsp%0d: at +%0d valid %b err %b expected +%0d %b 0", k,
                   at - a, rsp_valid, rsp_err, 3 + 5 * int'(T_LEN[k]), oh);
        end
        tick();
      end
    end
    n_cmp++;
    if (cmd_count !== 32'd2) begin
      n_fail++;
      $display("FAIL rej_count: got %0d expected 2", cmd_count);
    end
  endtask

  task automatic test_engine_busy();
    int a, at;
    tick();
    force_busy = 1'b1;
    set_req(2'd2, OP_SQRT, 16'h0000, 16'h0040, 16'd2);
    #1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL busy_hold%0d: ready %b expected 0000", i, req_ready);
      end
    end
    tick();
    force_busy = 1'b0;
    #1;
    a = cyc;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL busy_release: ready %b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    wait_rsp(40, at);
    n_cmp++;
    if (at != a + 13 || rsp_valid !== 4'b0100 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_rsp: at +%0d valid %b err %b expected +13 0100 0", at - a, rsp_valid,
               rsp_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int   a, at, n;
    logic bad_rsp, bad_busy;
    do_reset();
    set_req(2'd0, OP_EXP, 16'h0000, 16'h0010, 16'd1);
    #1;
    wait_ready(2'd0, 20, a);
    tick();
    req_valid = '0;
    wait_rsp(20, at);
    tick();
    n_cmp++;
    if (cmd_count !== 32'd1) begin
      n_fail++;
      $display("FAIL rstmid_precount: got %0d expected 1", cmd_count);
    end
    set_req(2'd0, OP_EXP, 16'h0020, 16'h0030, 16'd4);
    #1;
    wait_ready(2'd0, 20, a);
    tick();
    req_valid = '0;
    tick();
    tick();
    n_cmp++;
    if (sched_busy !== 1'b1 || me_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_in_wait: sched %b engine %b expected 1 1", sched_busy, me_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (sched_busy !== 1'b0 || cmd_count !== 32'd0 || rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_after: busy %b count %0d valid %b expected 0 0 0000", sched_busy,
               cmd_count, rsp_valid);
    end
    set_req(2'd0, OP_EXP, 16'h0000, 16'h0000, 16'd1);
    set_req(2'd1, OP_LOG, 16'h0000, 16'h0000, 16'd1);
    #1;
    bad_rsp  = 1'b0;
    bad_busy = 1'b0;
    n = 0;
    while (req_ready == 4'b0000 && n < 40) begin
      if (rsp_valid != 4'b0000) bad_rsp = 1'b1;
      tick();
      if (me_busy && req_ready != 4'b0000) bad_busy = 1'b1;
      n++;
    end
    n_cmp++;
    if (bad_rsp || bad_busy) begin
      n_fail++;
      $display("FAIL rstmid_quiet: stray rsp %b grant while busy %b expected 0 0", bad_rsp,
               bad_busy);
    end
    n_cmp++;
    if (req_ready !== 4'b0001 || me_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_regrant: ready %b busy %b expected 0001 0", req_ready, me_busy);
    end
    tick();
    req_valid = '0;
    wait_rsp(20, at);
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rsp: valid %b err %b expected 0001 0", rsp_valid, rsp_err);
    end
    tick();
  endtask

  task automatic test_spurious_done();
    logic [31:0] cnt0;
    tick();
    cnt0 = cmd_count;
    spur_done = 1'b1;
    #1;
    tick();
    spur_done = 1'b0;
    #1;
    n_cmp++;
    if (sched_busy !== 1'b0 || rsp_valid !== 4'b0000 || me_cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_state: busy %b valid %b cmd %b expected 0 0000 0", sched_busy,
               rsp_valid, me_cmd_valid);
    end
    tick();
    n_cmp++;
    if (cmd_count !== cnt0 || rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL spurious_count: count %0d valid %b expected %0d 0000", cmd_count, rsp_valid,
               cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_single_exp();
    test_round_robin();
    test_rejections();
    test_engine_busy();
    test_reset_mid();
    test_spurious_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
